// File: rtl/key_salt_stream.sv
// bcrypt key/salt word source: byte-serial key load, then cyclic 32-bit key words and alternating 64-bit salt halves.
// Key/salt words update 1 cycle after a strobe; load_ready depends on state only and drops once the key is READY.
module key_salt_stream #(
  parameter int MAX_KEY_BYTES = 72
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         clear,
  input  logic         load_valid,
  input  logic [7:0]   load_byte,
  input  logic         load_last,
  output logic         load_ready,
  input  logic         key_next,
  input  logic         rewind,
  output logic [31:0]  key_word,
  output logic         key_valid,
  output logic [6:0]   key_len,
  output logic         key_trunc,
  input  logic         salt_load,
  input  logic [127:0] salt,
  input  logic         salt_next,
  output logic [63:0]  salt_word
);

  typedef enum logic [2:0] {EMPTY, LOAD, DRAIN, PREP, READY} state_t;

  localparam logic [6:0] LAST_IDX = 7'(MAX_KEY_BYTES - 1);

  state_t        state_q, state_d;
  logic [6:0]    count_q, count_d;
  logic [6:0]    ptr_q, ptr_d;
  logic [6:0]    key_len_q, key_len_d;
  logic          key_trunc_q, key_trunc_d;
  logic [31:0]   key_word_q, key_word_d;
  logic [127:0]  salt_q, salt_d;
  logic          salt_lo_q, salt_lo_d;
  logic [63:0]   salt_word_q, salt_word_d;

  logic [7:0]    key_buf_q [MAX_KEY_BYTES];
  logic          buf_we;
  logic [6:0]    buf_widx;

  logic          accept, in_ready, use_zero;
  logic [6:0]    p1, p2, p3, p4, base, len_use, i1, i2, i3;
  logic [31:0]   word_at_base;

  // Single-step modular increment; chaining it keeps every L in 1..72 exact, including L < 4.
  function automatic logic [6:0] inc_idx(input logic [6:0] i, input logic [6:0] len);
    return (i + 7'd1 == len) ? 7'd0 : i + 7'd1;
  endfunction

  assign in_ready = (state_q == READY);
  assign p1 = inc_idx(ptr_q, key_len_q);
  assign p2 = inc_idx(p1, key_len_q);
  assign p3 = inc_idx(p2, key_len_q);
  assign p4 = inc_idx(p3, key_len_q);

  // PREP has not latched key_len yet, so the byte count stands in for it.
  assign use_zero = (state_q == PREP) || rewind;
  assign base     = use_zero ? 7'd0 : p4;
  assign len_use  = (state_q == PREP) ? count_q : key_len_q;
  assign i1 = inc_idx(base, len_use);
  assign i2 = inc_idx(i1, len_use);
  assign i3 = inc_idx(i2, len_use);
  assign word_at_base = {key_buf_q[base], key_buf_q[i1], key_buf_q[i2], key_buf_q[i3]};

  assign load_ready = (state_q == EMPTY) || (state_q == LOAD) || (state_q == DRAIN);
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    ptr_d       = ptr_q;
    key_len_d   = key_len_q;
    key_trunc_d = key_trunc_q;
    key_word_d  = key_word_q;
    salt_d      = salt_q;
    salt_lo_d   = salt_lo_q;
    salt_word_d = salt_word_q;
    buf_we      = 1'b0;
    buf_widx    = count_q;

    case (state_q)
      EMPTY: if (accept) begin
        buf_we   = 1'b1;
        buf_widx = 7'd0;
        count_d  = 7'd1;
        state_d  = load_last ? PREP : LOAD;
      end
      LOAD: if (accept) begin
        buf_we  = 1'b1;
        count_d = count_q + 7'd1;
        if (load_last) begin
          state_d = PREP;
        end else if (count_q == LAST_IDX) begin
          state_d     = DRAIN;
          key_trunc_d = 1'b1;
        end
      end
      DRAIN: if (accept && load_last) state_d = PREP;
      PREP: begin
        key_len_d  = count_q;
        ptr_d      = 7'd0;
        key_word_d = word_at_base;
        state_d    = READY;
      end
      READY: begin
        if (rewind) begin
          ptr_d      = 7'd0;
          key_word_d = word_at_base;
        end else if (key_next) begin
          ptr_d      = p4;
          key_word_d = word_at_base;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (salt_load) begin
      salt_d      = salt;
      salt_lo_d   = 1'b0;
      salt_word_d = salt[127:64];
    end else if (rewind && in_ready) begin
      salt_lo_d   = 1'b0;
      salt_word_d = salt_q[127:64];
    end else if (salt_next) begin
      salt_lo_d   = ~salt_lo_q;
      salt_word_d = salt_lo_q ? salt_q[127:64] : salt_q[63:0];
    end

    if (clear) begin
      state_d     = EMPTY;
      count_d     = 7'd0;
      ptr_d       = 7'd0;
      key_len_d   = 7'd0;
      key_trunc_d = 1'b0;
      key_word_d  = 32'd0;
      salt_d      = 128'd0;
      salt_lo_d   = 1'b0;
      salt_word_d = 64'd0;
      buf_we      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= EMPTY;
      count_q     <= 7'd0;
      ptr_q       <= 7'd0;
      key_len_q   <= 7'd0;
      key_trunc_q <= 1'b0;
      key_word_q  <= 32'd0;
      salt_q      <= 128'd0;
      salt_lo_q   <= 1'b0;
      salt_word_q <= 64'd0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ptr_q       <= ptr_d;
      key_len_q   <= key_len_d;
      key_trunc_q <= key_trunc_d;
      key_word_q  <= key_word_d;
      salt_q      <= salt_d;
      salt_lo_q   <= salt_lo_d;
      salt_word_q <= salt_word_d;
    end
  end

  // Key bytes carry no reset: only indices below key_len are ever read.
  always_ff @(posedge clk) begin
    if (buf_we) key_buf_q[buf_widx] <= load_byte;
  end

  assign key_word  = key_word_q;
  assign key_valid = in_ready;
  assign key_len   = key_len_q;
  assign key_trunc = key_trunc_q;
  assign salt_word = salt_word_q;

endmodule

// File: tb/tb_key_salt_stream.sv
// Directed bench for key_salt_stream: expected key/salt words come from a byte-array model via scoreboard queues.
module tb_key_salt_stream;

  logic         clk = 1'b0;
  logic         rst_l, clear, load_valid, load_last, load_ready;
  logic [7:0]   load_byte;
  logic         key_next, rewind, key_valid, key_trunc;
  logic [31:0]  key_word;
  logic [6:0]   key_len;
  logic         salt_load, salt_next;
  logic [127:0] salt;
  logic [63:0]  salt_word;

  int tests = 0;
  int fails = 0;

  logic [7:0]  kb [80];
  logic [7:0]  mb [72];
  int          m_len, m_ptr;
  logic [127:0] m_salt;
  bit          m_lo;
  logic [31:0] kexp [$];
  logic [63:0] sexp [$];

  localparam logic [127:0] SALT_A = 128'h00112233445566778899AABBCCDDEEFF;

  key_salt_stream dut (
    .clk(clk), .rst_l(rst_l), .clear(clear),
    .load_valid(load_valid), .load_byte(load_byte), .load_last(load_last), .load_ready(load_ready),
    .key_next(key_next), .rewind(rewind), .key_word(key_word), .key_valid(key_valid),
    .key_len(key_len), .key_trunc(key_trunc),
    .salt_load(salt_load), .salt(salt), .salt_next(salt_next), .salt_word(salt_word)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mword(input int p);
    return {mb[p], mb[(p + 1) % m_len], mb[(p + 2) % m_len], mb[(p + 3) % m_len]};
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_load_ready"}, load_ready, 1);
    chk({tag, "_key_valid"}, key_valid, 0);
    chk({tag, "_key_word"}, key_word, 0);
    chk({tag, "_key_len"}, key_len, 0);
    chk({tag, "_key_trunc"}, key_trunc, 0);
    chk({tag, "_salt_word"}, salt_word, 0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic load_key(input int n);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_byte  = kb[i];
      load_last  = (i == n - 1);
      chk("load_ready_during_load", load_ready, 1);
      step();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("prep_key_valid", key_valid, 0);
    step();
    m_len = (n > 72) ? 72 : n;
    m_ptr = 0;
    for (int i = 0; i < m_len; i++) mb[i] = kb[i];
    chk("ready_key_valid", key_valid, 1);
    chk("ready_load_ready", load_ready, 0);
    chk("ready_key_len", key_len, m_len);
    chk("ready_key_trunc", key_trunc, (n > 72));
    chk("ready_word0", key_word, mword(0));
  endtask

  task automatic key_step(input bit nx, input bit rw);
    key_next = nx;
    rewind   = rw;
    if (rw) m_ptr = 0;
    else if (nx) m_ptr = (m_ptr + 4) % m_len;
    kexp.push_back(mword(m_ptr));
    step();
    key_next = 1'b0;
    rewind   = 1'b0;
    chk("key_word", key_word, kexp.pop_front());
  endtask

  task automatic salt_step(input bit ld, input bit nx, input logic [127:0] s);
    salt_load = ld;
    salt_next = nx;
    salt      = s;
    if (ld) begin
      m_salt = s;
      m_lo   = 1'b0;
    end else if (nx) begin
      m_lo = ~m_lo;
    end
    sexp.push_back(m_lo ? m_salt[63:0] : m_salt[127:64]);
    step();
    salt_load = 1'b0;
    salt_next = 1'b0;
    chk("salt_word", salt_word, sexp.pop_front());
  endtask

  initial begin
    rst_l = 1'b0; clear = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_byte = 8'h00;
    key_next = 1'b0; rewind = 1'b0; salt_load = 1'b0; salt_next = 1'b0; salt = '0;
    m_len = 1; m_ptr = 0; m_salt = '0; m_lo = 1'b0;
    #12;
    chk_reset("por");
    rst_l = 1'b1;
    step();

    // key_next outside READY must be ignored
    key_next = 1'b1;
    step();
    key_next = 1'b0;
    chk("ignored_key_next", key_word, 0);

    // "abc\0"
    kb[0] = 8'h61; kb[1] = 8'h62; kb[2] = 8'h63; kb[3] = 8'h00;
    load_key(4);
    chk("abc_word0", key_word, 32'h61626300);
    for (int i = 0; i < 3; i++) key_step(1, 0);
    chk("abc_after_next", key_word, 32'h61626300);

    // five-byte key wrapping
    do_clear();
    chk_reset("clr1");
    for (int i = 0; i < 5; i++) kb[i] = 8'(i + 1);
    load_key(5);
    chk("k5_w0", key_word, 32'h01020304);
    key_step(1, 0);
    chk("k5_w4", key_word, 32'h05010203);
    key_step(1, 0);
    chk("k5_w3", key_word, 32'h04050102);
    key_step(0, 1);
    chk("k5_rewind", key_word, 32'h01020304);
    key_step(1, 0);
    key_step(1, 1);
    chk("k5_rewind_beats_next", key_word, 32'h01020304);

    // single-byte key
    do_clear();
    kb[0] = 8'hAA;
    load_key(1);
    chk("k1_w0", key_word, 32'hAAAAAAAA);
    for (int i = 0; i < 4; i++) key_step(1, 0);
    chk("k1_after_next", key_word, 32'hAAAAAAAA);

    // 80 bytes: truncation through DRAIN
    do_clear();
    for (int i = 0; i < 80; i++) kb[i] = 8'(i);
    load_key(80);
    chk("k80_trunc", key_trunc, 1);
    chk("k80_len", key_len, 72);
    for (int i = 0; i < 17; i++) key_step(1, 0);
    chk("k80_ptr68", key_word, 32'h44454647);
    key_step(1, 0);
    chk("k80_wrap", key_word, 32'h00010203);

    // salt halves
    salt_step(1, 0, SALT_A);
    chk("salt_upper", salt_word, 64'h0011223344556677);
    salt_step(0, 1, SALT_A);
    chk("salt_lower", salt_word, 64'h8899AABBCCDDEEFF);
    salt_step(0, 1, SALT_A);
    chk("salt_upper2", salt_word, 64'h0011223344556677);
    salt_step(0, 1, SALT_A);
    salt_step(1, 1, SALT_A);
    chk("salt_load_beats_next", salt_word, 64'h0011223344556677);
    salt_step(0, 1, SALT_A);
    key_step(0, 1);
    m_lo = 1'b0;
    chk("rewind_salt_upper", salt_word, 64'h0011223344556677);

    // async reset mid-load, then reload, then clear in READY
    do_clear();
    for (int i = 0; i < 10; i++) begin
      load_valid = 1'b1;
      load_byte  = 8'(8'hC0 + i);
      step();
    end
    load_valid = 1'b0;
    #2;
    rst_l = 1'b0;
    #1;
    chk_reset("arst");
    step();
    rst_l = 1'b1;
    step();
    kb[0] = 8'h10; kb[1] = 8'h20; kb[2] = 8'h30; kb[3] = 8'h40;
    load_key(4);
    chk("reload_w0", key_word, 32'h10203040);
    do_clear();
    chk_reset("clr_ready");
    kb[0] = 8'hDE; kb[1] = 8'hAD; kb[2] = 8'hBE; kb[3] = 8'hEF;
    load_key(4);
    chk("reload2_w0", key_word, 32'hDEADBEEF);
    key_step(1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
